// File: rtl/switch_drop_stats_pkg.sv
// Shared types and helpers for switch_drop_stats: snapshot FSM states and a
// popcount helper bounded to POPCOUNT_MAX_W bits, counting only the low 'width' bits.
package stats_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ACK
    } snap_state_e;

    localparam int unsigned POPCOUNT_MAX_W = 64;

    function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] vec,
                                             input int unsigned               width);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < POPCOUNT_MAX_W; i++) begin
            if ((i < width) && vec[i]) begin
                cnt++;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/switch_drop_stats_port_stat_ctr.sv
// Per-port statistics: saturating drop/accept/delivery counters, their snapshot
// shadows and a sticky saturation bit.
module port_stat_ctr
    import stats_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int POP_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_capture,
    input  logic                 i_drop,
    input  logic                 i_accept,
    input  logic                 i_deliver,
    input  logic [POP_W-1:0]     i_pop,
    output logic [CNT_WIDTH-1:0] o_shd_drops,
    output logic [CNT_WIDTH-1:0] o_shd_accepted,
    output logic [CNT_WIDTH-1:0] o_shd_delivered,
    output logic                 o_sat
);

    logic [CNT_WIDTH-1:0] r_drops;
    logic [CNT_WIDTH-1:0] r_accepted;
    logic [CNT_WIDTH-1:0] r_delivered;
    logic [CNT_WIDTH-1:0] r_shd_drops;
    logic [CNT_WIDTH-1:0] r_shd_accepted;
    logic [CNT_WIDTH-1:0] r_shd_delivered;
    logic                 r_sat;

    logic [CNT_WIDTH-1:0] w_pop_ext;
    logic [CNT_WIDTH:0]   w_drops_sum;
    logic [CNT_WIDTH:0]   w_accepted_sum;
    logic [CNT_WIDTH:0]   w_delivered_sum;
    logic                 w_ovf;

    // The extra top bit of each sum is the overflow carry used for clamping.
    assign w_pop_ext       = CNT_WIDTH'(i_pop);
    assign w_drops_sum     = {1'b0, r_drops}     + {1'b0, w_pop_ext};
    assign w_accepted_sum  = {1'b0, r_accepted}  + {1'b0, w_pop_ext};
    assign w_delivered_sum = {1'b0, r_delivered} + (CNT_WIDTH+1)'(1);

    assign w_ovf = (i_drop    & w_drops_sum[CNT_WIDTH])
                 | (i_accept  & w_accepted_sum[CNT_WIDTH])
                 | (i_deliver & w_delivered_sum[CNT_WIDTH]);

    function automatic logic [CNT_WIDTH-1:0] clamp(input logic [CNT_WIDTH:0] sum);
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    // NOTE: shadows are plain registers, not a RAM, so they take the async reset
    // like everything else; reset mid-snapshot must leave them zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drops         <= '0;
            r_accepted      <= '0;
            r_delivered     <= '0;
            r_shd_drops     <= '0;
            r_shd_accepted  <= '0;
            r_shd_delivered <= '0;
            r_sat           <= 1'b0;
        end else begin
            // NOTE: non-blocking here lets the shadow copy see the pre-update
            // live values even though both change on the same edge.
            if (i_capture) begin
                r_shd_drops     <= r_drops;
                r_shd_accepted  <= r_accepted;
                r_shd_delivered <= r_delivered;
            end
            if (i_clr) begin
                r_drops     <= '0;
                r_accepted  <= '0;
                r_delivered <= '0;
                r_sat       <= 1'b0;
            end else begin
                if (i_drop) begin
                    r_drops <= clamp(w_drops_sum);
                end
                if (i_accept) begin
                    r_accepted <= clamp(w_accepted_sum);
                end
                if (i_deliver) begin
                    r_delivered <= clamp(w_delivered_sum);
                end
                if (w_ovf) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign o_shd_drops     = r_shd_drops;
    assign o_shd_accepted  = r_shd_accepted;
    assign o_shd_delivered = r_shd_delivered;
    assign o_sat           = r_sat;

endmodule

// File: rtl/switch_drop_stats.sv
// N-port switch drop/accept/delivery statistics with request/ack snapshot readout.
// Optional in-flight underflow checker enabled by defining STATS_LOSS_CHECK_EN.
module switch_drop_stats
    import stats_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           valid_in,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] target_in,
    input  logic [NUM_PORTS-1:0]           fifo_full,
    input  logic [NUM_PORTS-1:0]           deliver_valid,
    input  logic                           clr,
    input  logic                           snap_req,
    output logic                           snap_ack,
    input  logic [$clog2(NUM_PORTS)-1:0]   rd_sel,
    output logic [CNT_WIDTH-1:0]           rd_drops,
    output logic [CNT_WIDTH-1:0]           rd_accepted,
    output logic [CNT_WIDTH-1:0]           rd_delivered,
    output logic [NUM_PORTS-1:0]           sat_flag,
    output logic                           loss_err
);

    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int POP_W = $clog2(NUM_PORTS + 1);

    snap_state_e r_state;
    snap_state_e w_state_next;
    logic        w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: defaulting w_state_next before the case keeps this block free of latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (snap_req)  w_state_next = CAPTURE;
            CAPTURE:                w_state_next = ACK;
            ACK:     if (!snap_req) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    assign w_capture = (r_state == CAPTURE);
    assign snap_ack  = (r_state == ACK);

    logic [POP_W-1:0]     w_pop           [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_drop;
    logic [NUM_PORTS-1:0] w_accept;
    logic [CNT_WIDTH-1:0] w_shd_drops     [NUM_PORTS];
    logic [CNT_WIDTH-1:0] w_shd_accepted  [NUM_PORTS];
    logic [CNT_WIDTH-1:0] w_shd_delivered [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign w_pop[gi] = POP_W'(popcount(POPCOUNT_MAX_W'(target_in[gi*NUM_PORTS +: NUM_PORTS]),
                                           NUM_PORTS));
        assign w_drop[gi]   = valid_in[gi] &  fifo_full[gi];
        assign w_accept[gi] = valid_in[gi] & ~fifo_full[gi];

        port_stat_ctr #(
            .CNT_WIDTH (CNT_WIDTH),
            .POP_W     (POP_W)
        ) u_ctr (
            .clk             (clk),
            .rst_n           (rst_n),
            .i_clr           (clr),
            .i_capture       (w_capture),
            .i_drop          (w_drop[gi]),
            .i_accept        (w_accept[gi]),
            .i_deliver       (deliver_valid[gi]),
            .i_pop           (w_pop[gi]),
            .o_shd_drops     (w_shd_drops[gi]),
            .o_shd_accepted  (w_shd_accepted[gi]),
            .o_shd_delivered (w_shd_delivered[gi]),
            .o_sat           (sat_flag[gi])
        );
    end

    // Out-of-range selects read as zero when NUM_PORTS is not a power of two.
    always_comb begin
        rd_drops     = '0;
        rd_accepted  = '0;
        rd_delivered = '0;
        if (int'(rd_sel) < NUM_PORTS) begin
            rd_drops     = w_shd_drops[rd_sel];
            rd_accepted  = w_shd_accepted[rd_sel];
            rd_delivered = w_shd_delivered[rd_sel];
        end
    end

`ifdef STATS_LOSS_CHECK_EN
    localparam int IF_W  = CNT_WIDTH + SEL_W;
    localparam int ACC_W = $clog2(NUM_PORTS * NUM_PORTS + 1);
    localparam int EXT_W = IF_W + ACC_W;

    logic [IF_W-1:0]  r_inflight;
    logic             r_loss_err;
    logic [EXT_W-1:0] w_acc_sum;
    logic [EXT_W-1:0] w_del_sum;
    logic [EXT_W-1:0] w_inc;
    logic [EXT_W-1:0] w_diff;
    logic [IF_W-1:0]  w_inflight_next;
    logic             w_underflow;

    // Targets accepted minus packets delivered; below zero means a delivery we never saw enter.
    always_comb begin
        w_acc_sum = '0;
        w_del_sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_accept[i]) begin
                w_acc_sum = w_acc_sum + EXT_W'(w_pop[i]);
            end
            if (deliver_valid[i]) begin
                w_del_sum = w_del_sum + EXT_W'(1);
            end
        end
        w_inc           = EXT_W'(r_inflight) + w_acc_sum;
        w_diff          = w_inc - w_del_sum;
        w_underflow     = (w_inc < w_del_sum);
        w_inflight_next = w_diff[IF_W-1:0];
        if (w_underflow) begin
            w_inflight_next = '0;
        end else if (|w_diff[EXT_W-1:IF_W]) begin
            w_inflight_next = {IF_W{1'b1}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_loss_err <= 1'b0;
        end else if (clr) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (w_underflow) begin
                r_loss_err <= 1'b1;
            end
        end
    end

    assign loss_err = r_loss_err;
`else
    assign loss_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_drop_stats.sv
// Bench for switch_drop_stats (NUM_PORTS=4, CNT_WIDTH=4): directed scenarios and a
// randomized run, every cycle compared against a count-level reference model.
module tb_switch_drop_stats;

    localparam int NP   = 4;
    localparam int CW   = 4;
    localparam int MAXV = (1 << CW) - 1;
    localparam int IF_MAX = (1 << (CW + 2)) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NP-1:0]  valid_in;
    logic [NP*NP-1:0] target_in;
    logic [NP-1:0]  fifo_full;
    logic [NP-1:0]  deliver_valid;
    logic           clr;
    logic           snap_req;
    logic           snap_ack;
    logic [1:0]     rd_sel;
    logic [CW-1:0]  rd_drops;
    logic [CW-1:0]  rd_accepted;
    logic [CW-1:0]  rd_delivered;
    logic [NP-1:0]  sat_flag;
    logic           loss_err;

    switch_drop_stats #(.NUM_PORTS(NP), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .target_in     (target_in),
        .fifo_full     (fifo_full),
        .deliver_valid (deliver_valid),
        .clr           (clr),
        .snap_req      (snap_req),
        .snap_ack      (snap_ack),
        .rd_sel        (rd_sel),
        .rd_drops      (rd_drops),
        .rd_accepted   (rd_accepted),
        .rd_delivered  (rd_delivered),
        .sat_flag      (sat_flag),
        .loss_err      (loss_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: live and shadow totals per port, snapshot progress, in-flight count.
    int m_drops [NP];
    int m_acc   [NP];
    int m_del   [NP];
    int s_drops [NP];
    int s_acc   [NP];
    int s_del   [NP];
    bit m_sat   [NP];
    int m_phase;            // 0 waiting, 1 capturing, 2 acknowledged
    int m_inflight;
    bit m_loss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) begin
            m_drops[i] = 0; m_acc[i] = 0; m_del[i] = 0;
            s_drops[i] = 0; s_acc[i] = 0; s_del[i] = 0;
            m_sat[i] = 1'b0;
        end
        m_phase    = 0;
        m_inflight = 0;
        m_loss     = 1'b0;
    endfunction

    function automatic int sat_add(input int v, input int a, input int p);
        if (v + a > MAXV) begin
            m_sat[p] = 1'b1;
            return MAXV;
        end
        return v + a;
    endfunction

    function automatic void model_step();
        int net;
        if (m_phase == 1) begin
            for (int i = 0; i < NP; i++) begin
                s_drops[i] = m_drops[i]; s_acc[i] = m_acc[i]; s_del[i] = m_del[i];
            end
        end
        if (clr) begin
            for (int i = 0; i < NP; i++) begin
                m_drops[i] = 0; m_acc[i] = 0; m_del[i] = 0; m_sat[i] = 1'b0;
            end
            m_inflight = 0;
        end else begin
            net = m_inflight;
            for (int i = 0; i < NP; i++) begin
                int t;
                t = $countones(target_in[i*NP +: NP]);
                if (valid_in[i] && fifo_full[i])  m_drops[i] = sat_add(m_drops[i], t, i);
                if (valid_in[i] && !fifo_full[i]) begin
                    m_acc[i] = sat_add(m_acc[i], t, i);
                    net += t;
                end
                if (deliver_valid[i]) begin
                    m_del[i] = sat_add(m_del[i], 1, i);
                    net -= 1;
                end
            end
            if (net < 0) begin
                net    = 0;
                m_loss = 1'b1;
            end
            m_inflight = (net > IF_MAX) ? IF_MAX : net;
        end
        case (m_phase)
            0:       if (snap_req)  m_phase = 1;
            1:                      m_phase = 2;
            default: if (!snap_req) m_phase = 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [NP-1:0] exp_sat;
        bit            exp_loss;
        for (int i = 0; i < NP; i++) exp_sat[i] = m_sat[i];
`ifdef STATS_LOSS_CHECK_EN
        exp_loss = m_loss;
`else
        exp_loss = 1'b0;
`endif
        check({tag, "_ack"},  snap_ack, (m_phase == 2) ? 1 : 0);
        check({tag, "_sat"},  sat_flag, exp_sat);
        check({tag, "_loss"}, loss_err, exp_loss);
        check({tag, "_rdd"},  rd_drops,     s_drops[rd_sel]);
        check({tag, "_rda"},  rd_accepted,  s_acc[rd_sel]);
        check({tag, "_rdv"},  rd_delivered, s_del[rd_sel]);
    endtask

    task automatic idle_inputs();
        valid_in = '0; fifo_full = '0; target_in = '0; deliver_valid = '0; clr = 1'b0;
    endtask

    task automatic snapshot(input string tag);
        snap_req = 1'b1;
        tick(); check_all(tag);
        tick(); check_all(tag);
        snap_req = 1'b0;
        tick(); check_all(tag);
    endtask

    task automatic read_all(input string tag);
        for (int p = 0; p < NP; p++) begin
            rd_sel = 2'(p);
            #1;
            check({tag, "_d"}, rd_drops,     s_drops[p]);
            check({tag, "_a"}, rd_accepted,  s_acc[p]);
            check({tag, "_v"}, rd_delivered, s_del[p]);
        end
    endtask

    initial begin
        rst_n = 1'b0; snap_req = 1'b0; rd_sel = '0;
        idle_inputs();
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Multicast drops: 3 targets for 3 cycles
        valid_in[0] = 1'b1; fifo_full[0] = 1'b1; target_in[3:0] = 4'b1011;
        repeat (3) begin tick(); check_all("drop3"); end
        idle_inputs();
        snapshot("snap1");
        rd_sel = 2'd0; #1;
        check("t1_drops", rd_drops, 9);
        check("t1_acc",   rd_accepted, 0);

        // Accept saturation on port 2, then clear
        valid_in[2] = 1'b1; target_in[11:8] = 4'b1111;
        repeat (5) begin tick(); check_all("accsat"); end
        check("t2_sat", sat_flag, 4'b0100);
        idle_inputs();
        snapshot("snap2");
        rd_sel = 2'd2; #1;
        check("t2_acc", rd_accepted, 15);
        clr = 1'b1; tick(); clr = 1'b0; check_all("clr");
        check("t2_sat_clr", sat_flag, 4'b0000);
        snapshot("snap3");
        read_all("t2_zero");

        // Clear beats a same-cycle drop
        valid_in[1] = 1'b1; fifo_full[1] = 1'b1; target_in[7:4] = 4'b0110; clr = 1'b1;
        tick(); check_all("clrdrop");
        idle_inputs();
        snapshot("snap4");
        rd_sel = 2'd1; #1;
        check("t3_drops", rd_drops, 0);

        // Event during CAPTURE misses this snapshot, lands in the next
        snap_req = 1'b1;
        tick(); check("t4_ack_cap", snap_ack, 0);
        valid_in[3] = 1'b1; fifo_full[3] = 1'b1; target_in[15:12] = 4'b0001;
        tick(); check("t4_ack_rise", snap_ack, 1);
        idle_inputs();
        rd_sel = 2'd3; #1;
        check("t4_shadow_old", rd_drops, 0);
        repeat (3) begin tick(); check_all("hold"); end
        check("t4_ack_hold", snap_ack, 1);
        snap_req = 1'b0;
        tick(); check("t4_ack_fall", snap_ack, 0);
        snapshot("snap5");
        rd_sel = 2'd3; #1;
        check("t4_shadow_new", rd_drops, 1);

`ifdef STATS_LOSS_CHECK_EN
        clr = 1'b1; tick(); clr = 1'b0;
        valid_in[0] = 1'b1; target_in[3:0] = 4'b0011;
        tick(); check_all("loss_acc");
        idle_inputs();
        deliver_valid = 4'b0001;
        tick(); check("t5_loss_a", loss_err, 0);
        tick(); check("t5_loss_b", loss_err, 0);
        tick(); check("t5_loss_c", loss_err, 1);
        idle_inputs();
        check_all("loss");
`endif

        // Randomized traffic with occasional clears and snapshot requests
        for (int c = 0; c < 400; c++) begin
            valid_in      = 4'($urandom);
            fifo_full     = 4'($urandom);
            target_in     = 16'($urandom);
            deliver_valid = 4'($urandom);
            clr           = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 4) == 0) snap_req = ~snap_req;
            rd_sel        = 2'($urandom);
            tick();
            check_all("rand");
        end
        idle_inputs();
        snap_req = 1'b0;
        repeat (3) tick();

        // Async reset while in ACK with nonzero state
        valid_in = 4'b1111; fifo_full = 4'b0101; target_in = 16'hFFFF; deliver_valid = 4'b1111;
        repeat (2) tick();
        idle_inputs();
        snap_req = 1'b1;
        tick(); tick();
        check_all("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_ack", snap_ack, 0);
        check("t6_sat", sat_flag, 0);
        check("t6_loss", loss_err, 0);
        read_all("t6_rd");
        snap_req = 1'b0;
        rst_n = 1'b1;
        tick(); check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
